cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The parameters SHALL be: s_line, default 256, cache line width in bits; s_burst, default 64, memory beat width in bits; TIMEOUT_CYCLES, default 1024, watchdog limit.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-003 The ports SHALL be, in this order:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- line_i, input, s_line, write-back line from the cache datapath.
- line_o, output, s_line, assembled fill line to the cache datapath.
- address_i, input, 32, line address from the cache.
- read_i, input, 1, line fill request.
- write_i, input, 1, line write-back request.
- resp_o, output, 1, transfer complete.
- burst_i, input, s_burst, read beat from memory.
- burst_o, output, s_burst, write beat to memory.
- address_o, output, 32, line address to memory.
- read_o, output, 1, memory read request.
- write_o, output, 1, memory write request.
- resp_i, input, 1, memory beat acknowledge.
- err_o, output, 1, timeout flag.

Function
REQ-004 The number of beats per line SHALL be BEATS = s_line/s_burst, which is 4 at the defaults; the beat counter SHALL be $clog2(BEATS) bits wide.
REQ-005 The FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-006 Requests SHALL be sampled only in IDLE; if read_i and write_i are both high, write SHALL take priority.
REQ-007 On acceptance, address_i SHALL be latched with its low $clog2(s_line/8) bits forced to zero, and, for a write, line_i SHALL be latched.
REQ-008 The FSM SHALL move to READ or WRITE on the cycle after the request is accepted.
REQ-009 read_o SHALL be high exactly while the FSM is in READ, and write_o exactly while it is in WRITE.
REQ-010 address_o SHALL hold the latched address throughout READ and WRITE.
REQ-011 A beat SHALL transfer on any cycle in READ or WRITE where resp_i=1; beats may be non-consecutive.
REQ-012 In READ, beat n (n = 0 first) SHALL be stored at line_o[n*s_burst +: s_burst].
REQ-013 In WRITE, burst_o SHALL present latched line slice n while beat n is pending, and SHALL change only after resp_i.
REQ-014 After the beat with index BEATS-1 transfers, the FSM SHALL enter DONE on the next cycle.
REQ-015 resp_o SHALL be a one-cycle pulse, high only in DONE; the FSM SHALL then return to IDLE unconditionally.
REQ-016 Minimum request-to-resp_o latency SHALL be BEATS+2 cycles (accept, BEATS beats, DONE).
REQ-017 line_o SHALL be valid when resp_o=1 and SHALL hold until the next READ writes into it.
REQ-018 resp_i received in IDLE or DONE SHALL be ignored.
REQ-019 read_i or write_i held high during DONE SHALL NOT start a new transfer until IDLE is reached.
REQ-020 The beat counter SHALL wrap to 0 on the final beat.

Reset
REQ-021 rst SHALL return the FSM to IDLE from any state, including mid-burst, and discard partial beats.
REQ-022 Reset values SHALL be: read_o=0, write_o=0, resp_o=0, err_o=0, line_o=0, burst_o=0, address_o=0, and beat counter=0.

Configuration
REQ-023 With CACHELINE_ADAPTOR_TIMEOUT_EN defined, a counter SHALL clear on every beat and on entry to READ or WRITE, and increment on each READ or WRITE cycle without resp_i.
REQ-024 With CACHELINE_ADAPTOR_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set err_o, which is sticky until rst, and SHALL force DONE; line_o SHALL keep the partially filled contents.
REQ-025 Without CACHELINE_ADAPTOR_TIMEOUT_EN, err_o SHALL be tied to 0, no counter SHALL exist, and the FSM SHALL wait indefinitely for resp_i.

Structure
REQ-026 The cla_state_t enum (IDLE, READ, WRITE, DONE) and the BEATS constant SHALL live in the shared cache_types package.
REQ-027 One sub-module, cla_beat_counter, SHALL be used: a modulo-BEATS counter with clear and increment inputs and a last-beat output.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Read, address_i=0x0000_1234, resp_i on 4 consecutive cycles with beats 0xA..0, 0xB..1, 0xC..2, 0xD..3 -> address_o=0x0000_1220; line_o={D,C,B,A}; resp_o one cycle, 6 cycles after the request.
- Write, line_i=256'h0123..., resp_i gapped by 2 idle cycles between beats -> burst_o steps through the 64-bit slices low to high, each held until acknowledged; resp_o once.
- read_i=write_i=1 in IDLE -> write_o=1, read_o=0.
- rst asserted after 2 read beats -> next cycle read_o=0 and FSM in IDLE; a new read fills line_o with no stale beats.
- With CACHELINE_ADAPTOR_TIMEOUT_EN and TIMEOUT_CYCLES=8, no resp_i -> err_o=1 and resp_o pulse after 8 stalled cycles; err_o stays 1 until rst.
- Back-to-back: read_i held through DONE -> second read_o rises only after one IDLE cycle.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the cache-line adaptor: FSM state encoding and beat constants.
package cache_types;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } cla_state_t;

    localparam int unsigned LINE_BITS  = 256;
    localparam int unsigned BURST_BITS = 64;
    localparam int unsigned BEATS      = LINE_BITS / BURST_BITS;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_beat_counter.sv
// Modulo-BEATS_N beat index with synchronous clear and a last-beat flag.
module cla_beat_counter
    import cache_types::*;
#(
    parameter int unsigned BEATS_N = BEATS,
    parameter int unsigned W       = cnt_width(BEATS_N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(BEATS_N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Bridges a full cache line to a beat-wise memory burst, in both directions.
// Optional watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN to enable err_o / forced DONE.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int unsigned s_line         = 256,
    parameter int unsigned s_burst        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i,
    output logic                err_o
);

    localparam int unsigned N_BEATS = s_line / s_burst;
    localparam int unsigned CW      = cnt_width(N_BEATS);
    localparam int unsigned OFS     = $clog2(s_line / 8);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFS) - 32'd1);

    cla_state_t        state;
    logic [s_line-1:0] wr_line;
    logic [CW-1:0]     beat;
    logic [CW-1:0]     next_beat;
    logic              beat_last;
    logic              xfer_active;
    logic              beat_clr;
    logic              timeout_hit;

    assign xfer_active = (state == READ) || (state == WRITE);
    assign beat_clr    = (state == IDLE) || timeout_hit;
    assign next_beat   = beat_last ? '0 : beat + 1'b1;

    cla_beat_counter #(
        .BEATS_N (N_BEATS),
        .W       (CW)
    ) u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (beat_clr),
        .inc   (xfer_active && resp_i),
        .count (beat),
        .last  (beat_last)
    );

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt;

    // Counter sits at zero outside a transfer, so entering READ/WRITE starts it fresh.
    always_ff @(posedge clk) begin
        if (rst || !xfer_active || resp_i) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = xfer_active && !resp_i && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (timeout_hit) begin
            err_o <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            wr_line   <= '0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        state     <= WRITE;
                        write_o   <= 1'b1;
                        address_o <= address_i & ADDR_MASK;
                        wr_line   <= line_i;
                        burst_o   <= line_i[s_burst-1:0];
                    end else if (read_i) begin
                        state     <= READ;
                        read_o    <= 1'b1;
                        address_o <= address_i & ADDR_MASK;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[beat*s_burst +: s_burst] <= burst_i;
                        if (beat_last) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state  <= DONE;
                        read_o <= 1'b0;
                        resp_o <= 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        burst_o <= wr_line[next_beat*s_burst +: s_burst];
                        if (beat_last) begin
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        write_o <= 1'b0;
                        resp_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
